// File: rtl/mic1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mic1_pkg
// Purpose  : Shared constants for the Mic-1 register/bus core. Holds the MIR
//            field bit positions (C-write enables and memory control bits)
//            and the B-bus select encodings.
// Revision : 1.0  initial release
// ============================================================================
package mic1_pkg;

  // C-bus write enables: MIR bit index for each register
  localparam int unsigned c_mir_h   = 15;
  localparam int unsigned c_mir_opc = 14;
  localparam int unsigned c_mir_tos = 13;
  localparam int unsigned c_mir_cpp = 12;
  localparam int unsigned c_mir_lv  = 11;
  localparam int unsigned c_mir_sp  = 10;
  localparam int unsigned c_mir_pc  = 9;
  localparam int unsigned c_mir_mdr = 8;
  localparam int unsigned c_mir_mar = 7;

  // Memory control bits
  localparam int unsigned c_mir_write = 6;
  localparam int unsigned c_mir_read  = 5;
  localparam int unsigned c_mir_fetch = 4;

  // B-bus select encodings (MIR[3:0]); 9..15 drive zero
  localparam logic [3:0] c_bsel_mdr  = 4'd0;
  localparam logic [3:0] c_bsel_pc   = 4'd1;
  localparam logic [3:0] c_bsel_mbr  = 4'd2;
  localparam logic [3:0] c_bsel_mbru = 4'd3;
  localparam logic [3:0] c_bsel_sp   = 4'd4;
  localparam logic [3:0] c_bsel_lv   = 4'd5;
  localparam logic [3:0] c_bsel_cpp  = 4'd6;
  localparam logic [3:0] c_bsel_tos  = 4'd7;
  localparam logic [3:0] c_bsel_opc  = 4'd8;

endpackage : mic1_pkg
`default_nettype wire

// File: rtl/mic1_b_mux.sv
`default_nettype none
// ============================================================================
// Module   : mic1_b_mux
// Purpose  : B-bus multiplexer of the Mic-1 datapath, including sign/zero
//            extension of the 8-bit MBR.
// Ports    : sel  in  4   B-bus select (MIR[3:0])
//            mdr, pc, sp, lv, cpp, tos, opc  in 32  register views
//            mbr  in  8   MBR contents
//            b    out 32  B bus
// Revision : 1.0  initial release
// ============================================================================
module mic1_b_mux
  import mic1_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] mdr,
  input  logic [31:0] pc,
  input  logic [7:0]  mbr,
  input  logic [31:0] sp,
  input  logic [31:0] lv,
  input  logic [31:0] cpp,
  input  logic [31:0] tos,
  input  logic [31:0] opc,
  output logic [31:0] b
);

  always_comb begin
    b = 32'h0;
    case (sel)
      c_bsel_mdr:  b = mdr;
      c_bsel_pc:   b = pc;
      c_bsel_mbr:  b = {{24{mbr[7]}}, mbr};
      c_bsel_mbru: b = {24'h0, mbr};
      c_bsel_sp:   b = sp;
      c_bsel_lv:   b = lv;
      c_bsel_cpp:  b = cpp;
      c_bsel_tos:  b = tos;
      c_bsel_opc:  b = opc;
      default:     b = 32'h0;
    endcase
  end

endmodule : mic1_b_mux
`default_nettype wire

// File: rtl/mic1.sv
`default_nettype none
// ============================================================================
// Module   : mic1
// Purpose  : Register-file and bus-routing core of the Mic-1 datapath. Holds
//            H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR and MBR; drives the A and
//            B buses to an external ALU/shifter and writes back the C bus.
// Ports    : clock     in  1   rising-edge clock
//            reset_n   in  1   asynchronous active-low reset
//            ROM_data  in  32  instruction-fetch data, [7:0] used
//            RAM_data  in  32  data-memory read word
//            C         in  32  C bus from ALU/shifter
//            MIR       in  16  [15:7] C enables, [6:4] WRITE/READ/FETCH,
//                              [3:0] B select
//            MAR, MDR, PC  out 32  register views
//            MBR       out 32  MBR zero-extended
//            A         out 32  A bus (H)
//            B         out 32  B bus
// Revision : 1.0  initial release
// ============================================================================
module mic1
  import mic1_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ROM_data,
  input  logic [31:0] RAM_data,
  input  logic [31:0] C,
  input  logic [15:0] MIR,
  output logic [31:0] MAR,
  output logic [31:0] MDR,
  output logic [31:0] PC,
  output logic [31:0] MBR,
  output logic [31:0] A,
  output logic [31:0] B
);

  logic [31:0] h_q,   h_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] tos_q, tos_d;
  logic [31:0] cpp_q, cpp_d;
  logic [31:0] lv_q,  lv_d;
  logic [31:0] sp_q,  sp_d;
  logic [31:0] pc_q,  pc_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] mar_q, mar_d;
  logic [7:0]  mbr_q, mbr_d;

  // WRITE is sampled by external memory directly; upper ROM bits unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, ROM_data[31:8], MIR[c_mir_write]};

  always_comb begin
    h_d   = MIR[c_mir_h]   ? C : h_q;
    opc_d = MIR[c_mir_opc] ? C : opc_q;
    tos_d = MIR[c_mir_tos] ? C : tos_q;
    cpp_d = MIR[c_mir_cpp] ? C : cpp_q;
    lv_d  = MIR[c_mir_lv]  ? C : lv_q;
    sp_d  = MIR[c_mir_sp]  ? C : sp_q;
    pc_d  = MIR[c_mir_pc]  ? C : pc_q;
    mar_d = MIR[c_mir_mar] ? C : mar_q;
    mbr_d = MIR[c_mir_fetch] ? ROM_data[7:0] : mbr_q;
    // Memory read wins over a C-bus write of MDR in the same cycle.
    mdr_d = mdr_q;
    if (MIR[c_mir_mdr]) mdr_d = C;
    if (MIR[c_mir_read]) mdr_d = RAM_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q   <= 32'h0;
      opc_q <= 32'h0;
      tos_q <= 32'h0;
      cpp_q <= 32'h0;
      lv_q  <= 32'h0;
      sp_q  <= 32'h0;
      pc_q  <= 32'h0;
      mdr_q <= 32'h0;
      mar_q <= 32'h0;
      mbr_q <= 8'h0;
    end else begin
      h_q   <= h_d;
      opc_q <= opc_d;
      tos_q <= tos_d;
      cpp_q <= cpp_d;
      lv_q  <= lv_d;
      sp_q  <= sp_d;
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
      mar_q <= mar_d;
      mbr_q <= mbr_d;
    end
  end

  mic1_b_mux u_b_mux (
    .sel (MIR[3:0]),
    .mdr (mdr_q),
    .pc  (pc_q),
    .mbr (mbr_q),
    .sp  (sp_q),
    .lv  (lv_q),
    .cpp (cpp_q),
    .tos (tos_q),
    .opc (opc_q),
    .b   (B)
  );

  assign A   = h_q;
  assign MAR = mar_q;
  assign MDR = mdr_q;
  assign PC  = pc_q;
  assign MBR = {24'h0, mbr_q};

endmodule : mic1
`default_nettype wire

// File: tb/tb_mic1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic1
// Purpose  : Directed self-checking bench for mic1.
// Revision : 1.0  initial release
// ============================================================================
module tb_mic1;

  logic        clock;
  logic        reset_n;
  logic [31:0] ROM_data;
  logic [31:0] RAM_data;
  logic [31:0] C;
  logic [15:0] MIR;
  logic [31:0] MAR, MDR, PC, MBR, A, B;

  int n_tests;
  int n_fail;

  mic1 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ROM_data (ROM_data),
    .RAM_data (RAM_data),
    .C        (C),
    .MIR      (MIR),
    .MAR      (MAR),
    .MDR      (MDR),
    .PC       (PC),
    .MBR      (MBR),
    .A        (A),
    .B        (B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " MAR"}, MAR, 32'h0);
    check({tag, " MDR"}, MDR, 32'h0);
    check({tag, " PC"},  PC,  32'h0);
    check({tag, " MBR"}, MBR, 32'h0);
    check({tag, " A"},   A,   32'h0);
    check({tag, " B"},   B,   32'h0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    MIR      = 16'h0000;
    C        = 32'h0;
    ROM_data = 32'h0;
    RAM_data = 32'h0;

    // Reset: values clear with no clock edge needed, and stay cleared.
    #2;
    check_all_zero("rst_async");
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_all_zero("idle");

    // PC write with B = PC
    MIR = 16'h0201; C = 32'd5;
    step();
    check("pc_load PC", PC, 32'd5);
    check("pc_load B", B, 32'd5);
    check("pc_load MAR", MAR, 32'h0);
    check("pc_load MDR", MDR, 32'h0);
    check("pc_load A", A, 32'h0);

    // Same-cycle read (B=PC=5) and write (C=6)
    C = 32'd6;
    #1;
    check("rw_pre B", B, 32'd5);
    step();
    check("rw_post PC", PC, 32'd6);

    // H / A bus
    MIR = 16'h8000; C = 32'h7;
    step();
    check("h_load A", A, 32'h7);
    MIR = 16'h0000; C = 32'h9;
    step();
    check("h_hold A", A, 32'h7);
    check("h_hold PC", PC, 32'd6);

    // Fetch and MBR extension
    MIR = 16'h0012; ROM_data = 32'h0000_00F0;
    step();
    check("fetch MBR", MBR, 32'h0000_00F0);
    check("fetch B sext", B, 32'hFFFF_FFF0);
    MIR = 16'h0003; ROM_data = 32'h0000_0011;
    #1;
    check("fetch B zext", B, 32'h0000_00F0);
    step();
    check("nofetch MBR", MBR, 32'h0000_00F0);

    // Read priority over MDR C-write, plus MAR multi-write
    MIR = 16'h01A0; C = 32'h55; RAM_data = 32'hAA;
    step();
    check("read MAR", MAR, 32'h55);
    check("read MDR", MDR, 32'hAA);
    MIR = 16'h0000;
    #1;
    check("bsel0 B", B, 32'hAA);
    MIR = 16'h000C;
    #1;
    check("bsel12 B", B, 32'h0);

    // WRITE bit alone changes nothing
    MIR = 16'h0040; C = 32'h33; RAM_data = 32'h44;
    step();
    check("write MDR", MDR, 32'hAA);
    check("write MAR", MAR, 32'h55);

    // MDR loaded from C when no READ
    MIR = 16'h0100; C = 32'h123;
    step();
    check("mdr_c MDR", MDR, 32'h123);

    // Distinct values into OPC, TOS, CPP, LV, SP; read each back via B
    for (int i = 0; i < 5; i++) begin
      MIR = 16'h4000 >> i;
      C   = 32'h100 + 32'(i);
      step();
    end
    MIR = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      MIR = 16'(8 - i);
      #1;
      check($sformatf("bsel%0d B", 8 - i), B, 32'h100 + 32'(i));
    end
    check("regs A", A, 32'h7);
    check("regs PC", PC, 32'd6);

    // Async reset mid-cycle
    MIR = 16'h0201; C = 32'd5;
    step();
    check("pre_rst PC", PC, 32'd5);
    MIR = 16'h0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst PC", PC, 32'h0);
    check("mid_rst A", A, 32'h0);
    check("mid_rst MAR", MAR, 32'h0);
    check("mid_rst MDR", MDR, 32'h0);
    check("mid_rst MBR", MBR, 32'h0);
    // Pending load overridden while reset held
    MIR = 16'h0201; C = 32'd9;
    step();
    check("held_rst PC", PC, 32'h0);
    reset_n = 1'b1;
    step();
    check("post_rst PC", PC, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mic1
`default_nettype wire
